// File: rtl/otbn_dmem_arb_if.sv
`default_nettype none
// ============================================================================
// Module : otbn_dmem_arb_if
// Brief  : LSU, host and DMEM buses seen by the OTBN DMEM arbiter.
// Rev    : 1.0 - initial release
// ============================================================================

interface otbn_dmem_arb_if #(
  parameter int DmemAddrWidth    = 12,
  parameter int ExtWLEN          = 312,
  parameter int BaseWordsPerWLEN = 8
);

  // Core load-store unit
  logic                        core_req_i;
  logic                        core_write_i;
  logic [DmemAddrWidth-1:0]    core_addr_i;
  logic [ExtWLEN-1:0]          core_wdata_i;
  logic [ExtWLEN-1:0]          core_wmask_i;
  logic [BaseWordsPerWLEN-1:0] core_rmask_i;
  logic [ExtWLEN-1:0]          core_rdata_o;
  logic                        core_rvalid_o;
  logic                        core_rerror_o;

  // Host access port
  logic                        host_req_i;
  logic                        host_write_i;
  logic [DmemAddrWidth-1:0]    host_addr_i;
  logic [ExtWLEN-1:0]          host_wdata_i;
  logic [ExtWLEN-1:0]          host_wmask_i;
  logic                        host_gnt_o;
  logic [ExtWLEN-1:0]          host_rdata_o;
  logic                        host_rvalid_o;
  logic                        host_rerror_o;

  // DMEM macro
  logic                        dmem_req_o;
  logic                        dmem_write_o;
  logic [DmemAddrWidth-1:0]    dmem_addr_o;
  logic [ExtWLEN-1:0]          dmem_wdata_o;
  logic [ExtWLEN-1:0]          dmem_wmask_o;
  logic [BaseWordsPerWLEN-1:0] dmem_rmask_o;
  logic [ExtWLEN-1:0]          dmem_rdata_i;
  logic                        dmem_rvalid_i;
  logic                        dmem_rerror_i;

  // Arbiter side
  modport slave (
    input  core_req_i, core_write_i, core_addr_i, core_wdata_i, core_wmask_i,
           core_rmask_i,
    output core_rdata_o, core_rvalid_o, core_rerror_o,
    input  host_req_i, host_write_i, host_addr_i, host_wdata_i, host_wmask_i,
    output host_gnt_o, host_rdata_o, host_rvalid_o, host_rerror_o,
    output dmem_req_o, dmem_write_o, dmem_addr_o, dmem_wdata_o, dmem_wmask_o,
           dmem_rmask_o,
    input  dmem_rdata_i, dmem_rvalid_i, dmem_rerror_i
  );

  // Environment side (LSU, host adapter and DMEM macro together)
  modport master (
    output core_req_i, core_write_i, core_addr_i, core_wdata_i, core_wmask_i,
           core_rmask_i,
    input  core_rdata_o, core_rvalid_o, core_rerror_o,
    output host_req_i, host_write_i, host_addr_i, host_wdata_i, host_wmask_i,
    input  host_gnt_o, host_rdata_o, host_rvalid_o, host_rerror_o,
    input  dmem_req_o, dmem_write_o, dmem_addr_o, dmem_wdata_o, dmem_wmask_o,
           dmem_rmask_o,
    output dmem_rdata_i, dmem_rvalid_i, dmem_rerror_i
  );

endinterface

`default_nettype wire

// File: rtl/otbn_dmem_arb.sv
`default_nettype none
// ============================================================================
// Module : otbn_dmem_arb
// Brief  : Fixed-priority DMEM arbiter (core LSU over host) with response
//          steering, busy blocking, host starvation and protocol monitoring.
// Rev    : 1.0 - initial release
// ============================================================================

module otbn_dmem_arb #(
  parameter int  DmemSizeByte     = 4096,
  parameter int  StallLimit       = 16,
  parameter int  ExtWLEN          = 312,
  parameter int  BaseWordsPerWLEN = 8,
  localparam int DmemAddrWidth    = (DmemSizeByte > 1) ? $clog2(DmemSizeByte) : 1
) (
  input  wire logic      clk_i,
  input  wire logic      rst_ni,
  input  wire logic      busy_i,
  otbn_dmem_arb_if.slave bus,
  output logic           host_starve_o,
  output logic           proto_err_o
);

  localparam logic [2:0] RSP_NONE     = 3'd0;
  localparam logic [2:0] RSP_CORE_RD  = 3'd1;
  localparam logic [2:0] RSP_HOST_RD  = 3'd2;
  localparam logic [2:0] RSP_HOST_WR  = 3'd3;
  localparam logic [2:0] RSP_HOST_ERR = 3'd4;

  localparam logic [7:0] STALL_LAST   = 8'(StallLimit - 1);

  // Request path
  logic                        w_dmem_req;
  logic                        w_dmem_write;
  logic [DmemAddrWidth-1:0]    w_dmem_addr;
  logic [ExtWLEN-1:0]          w_dmem_wdata;
  logic [ExtWLEN-1:0]          w_dmem_wmask;
  logic [BaseWordsPerWLEN-1:0] w_dmem_rmask;
  logic                        w_host_gnt;

  // Response tracking
  logic [2:0]                  r_rsp;
  logic [2:0]                  w_rsp_d;

  // Response path
  logic                        w_core_rvalid;
  logic                        w_core_rerror;
  logic [ExtWLEN-1:0]          w_core_rdata;
  logic                        w_host_rvalid;
  logic                        w_host_rerror;
  logic [ExtWLEN-1:0]          w_host_rdata;
  logic                        w_rd_pending;

  // Monitors
  logic                        w_proto_viol;
  logic                        r_proto_err;
  logic                        w_host_stall;
  logic                        w_host_starve;
  logic [7:0]                  r_stall_cnt;

  // --------------------------------------------------------------------------
  // Response tracking register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rsp <= RSP_NONE;
    end else begin
      r_rsp <= w_rsp_d;
    end
  end

  // --------------------------------------------------------------------------
  // Arbitration and next tracking state
  // --------------------------------------------------------------------------
  // A blocked host request is still granted so the host adapter can move on;
  // it never reaches DMEM and is answered from the tracking state alone.
  always_comb begin
    w_dmem_req   = 1'b0;
    w_dmem_write = 1'b0;
    w_dmem_addr  = '0;
    w_dmem_wdata = '0;
    w_dmem_wmask = '0;
    w_dmem_rmask = '0;
    w_host_gnt   = 1'b0;
    w_rsp_d      = RSP_NONE;

    if (bus.core_req_i) begin
      w_dmem_req   = 1'b1;
      w_dmem_write = bus.core_write_i;
      w_dmem_addr  = bus.core_addr_i;
      w_dmem_wdata = bus.core_wdata_i;
      w_dmem_wmask = bus.core_wmask_i;
      w_dmem_rmask = bus.core_rmask_i;
      w_rsp_d      = bus.core_write_i ? RSP_NONE : RSP_CORE_RD;
    end else if (bus.host_req_i) begin
      w_host_gnt = 1'b1;
      if (busy_i) begin
        w_rsp_d = RSP_HOST_ERR;
      end else begin
        w_dmem_req   = 1'b1;
        w_dmem_write = bus.host_write_i;
        w_dmem_addr  = bus.host_addr_i;
        w_dmem_wdata = bus.host_wdata_i;
        w_dmem_wmask = bus.host_wmask_i;
        w_dmem_rmask = '1;
        w_rsp_d      = bus.host_write_i ? RSP_HOST_WR : RSP_HOST_RD;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Response steering
  // --------------------------------------------------------------------------
  always_comb begin
    w_core_rvalid = 1'b0;
    w_core_rerror = 1'b0;
    w_core_rdata  = '0;
    w_host_rvalid = 1'b0;
    w_host_rerror = 1'b0;
    w_host_rdata  = '0;
    w_rd_pending  = 1'b0;

    case (r_rsp)
      RSP_CORE_RD: begin
        w_rd_pending  = 1'b1;
        w_core_rvalid = bus.dmem_rvalid_i;
        w_core_rerror = bus.dmem_rvalid_i & bus.dmem_rerror_i;
        w_core_rdata  = bus.dmem_rdata_i;
      end
      RSP_HOST_RD: begin
        w_rd_pending  = 1'b1;
        w_host_rvalid = bus.dmem_rvalid_i;
        w_host_rerror = bus.dmem_rvalid_i & bus.dmem_rerror_i;
        w_host_rdata  = bus.dmem_rdata_i;
      end
      RSP_HOST_WR: begin
        w_host_rvalid = 1'b1;
      end
      RSP_HOST_ERR: begin
        w_host_rvalid = 1'b1;
        w_host_rerror = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // DMEM protocol check: rvalid must line up exactly with tracked reads
  // --------------------------------------------------------------------------
  assign w_proto_viol = bus.dmem_rvalid_i ^ w_rd_pending;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_proto_err <= 1'b0;
    end else if (w_proto_viol) begin
      r_proto_err <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Host starvation monitor
  // --------------------------------------------------------------------------
  // The pulse fires in the stall cycle that completes StallLimit consecutive
  // stalls; the count then restarts while the host keeps waiting.
  assign w_host_stall  = bus.host_req_i & ~w_host_gnt;
  assign w_host_starve = w_host_stall & (r_stall_cnt == STALL_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall_cnt <= 8'd0;
    end else if (!w_host_stall || w_host_starve) begin
      r_stall_cnt <= 8'd0;
    end else begin
      r_stall_cnt <= r_stall_cnt + 8'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.dmem_req_o    = w_dmem_req;
  assign bus.dmem_write_o  = w_dmem_write;
  assign bus.dmem_addr_o   = w_dmem_addr;
  assign bus.dmem_wdata_o  = w_dmem_wdata;
  assign bus.dmem_wmask_o  = w_dmem_wmask;
  assign bus.dmem_rmask_o  = w_dmem_rmask;

  assign bus.host_gnt_o    = w_host_gnt;

  assign bus.core_rvalid_o = w_core_rvalid;
  assign bus.core_rerror_o = w_core_rerror;
  assign bus.core_rdata_o  = w_core_rdata;
  assign bus.host_rvalid_o = w_host_rvalid;
  assign bus.host_rerror_o = w_host_rerror;
  assign bus.host_rdata_o  = w_host_rdata;

  assign host_starve_o     = w_host_starve;
  assign proto_err_o       = r_proto_err;

endmodule

`default_nettype wire

// File: tb/tb_otbn_dmem_arb.sv
`default_nettype none
// ============================================================================
// Module : tb_otbn_dmem_arb
// Brief  : Directed scoreboard bench for otbn_dmem_arb with a 1-cycle DMEM model.
// Rev    : 1.0 - initial release
// ============================================================================

module tb_otbn_dmem_arb;

  localparam int AW = 12;
  localparam int W  = 312;

  localparam logic [W-1:0] PAT_A5 = {39{8'hA5}};
  localparam logic [W-1:0] PAT_3C = {39{8'h3C}};
  localparam logic [W-1:0] PAT_5A = {39{8'h5A}};
  localparam logic [W-1:0] PAT_77 = {39{8'h77}};
  localparam logic [W-1:0] PAT_11 = {39{8'h11}};
  localparam logic [W-1:0] PAT_22 = {39{8'h22}};

  typedef struct {
    int           kind;   // 1: core response, 2: host response
    bit           err;
    logic [W-1:0] data;
    int           due;
  } exp_t;

  logic clk;
  logic rst_ni;
  logic busy;
  logic host_starve;
  logic proto_err;
  bit   inj_rv;
  bit   drop_rv;
  bit   err_rv;

  int   n_tests;
  int   n_fail;
  int   cycle_no;
  exp_t q[$];

  logic [W-1:0] mem [0:4095];

  otbn_dmem_arb_if #(.DmemAddrWidth(AW), .ExtWLEN(W), .BaseWordsPerWLEN(8)) bus ();

  otbn_dmem_arb #(
    .DmemSizeByte     (4096),
    .StallLimit       (16),
    .ExtWLEN          (W),
    .BaseWordsPerWLEN (8)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .busy_i        (busy),
    .bus           (bus),
    .host_starve_o (host_starve),
    .proto_err_o   (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle_no++;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cycle_no);
    end
  endtask

  // DMEM macro model: answers reads one cycle after the request
  initial begin : dmem_model
    logic [AW-1:0] a;
    bit rd, inj, drop, err;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[12'h040] = PAT_A5;
    mem[12'h080] = PAT_3C;
    mem[12'h100] = PAT_5A;
    mem[12'h300] = PAT_77;
    bus.dmem_rvalid_i = 1'b0;
    bus.dmem_rdata_i  = '0;
    bus.dmem_rerror_i = 1'b0;
    forever begin
      @(posedge clk);
      rd   = bus.dmem_req_o && !bus.dmem_write_o;
      a    = bus.dmem_addr_o;
      inj  = inj_rv;
      drop = drop_rv;
      err  = err_rv;
      if (bus.dmem_req_o && bus.dmem_write_o)
        mem[a] = (mem[a] & ~bus.dmem_wmask_o) | (bus.dmem_wdata_o & bus.dmem_wmask_o);
      #1;
      bus.dmem_rvalid_i = (rd && !drop) || inj;
      bus.dmem_rdata_i  = rd ? mem[a] : '0;
      bus.dmem_rerror_i = rd && err;
    end
  end

  // Response monitor: pops one expectation per observed response
  always @(negedge clk) begin
    int   akind;
    exp_t e;
    if (rst_ni) begin
      akind = (bus.core_rvalid_o && bus.host_rvalid_o) ? 3 :
              bus.core_rvalid_o ? 1 : bus.host_rvalid_o ? 2 : 0;
      if (akind != 0) begin
        if (q.size() == 0) begin
          chk("unexpected_rsp", akind, 0);
        end else begin
          e = q.pop_front();
          chk("rsp_kind", akind, e.kind);
          chk("rsp_cycle", cycle_no, e.due);
          if (e.kind == 1) begin
            chk("core_rerror", bus.core_rerror_o, e.err);
            chk("core_rdata", bus.core_rdata_o, e.data);
            chk("host_rdata_idle", bus.host_rdata_o, '0);
          end else begin
            chk("host_rerror", bus.host_rerror_o, e.err);
            chk("host_rdata", bus.host_rdata_o, e.data);
            chk("core_rdata_idle", bus.core_rdata_o, '0);
          end
        end
      end else if (q.size() != 0 && q[0].due <= cycle_no) begin
        e = q.pop_front();
        chk("missing_rsp", akind, e.kind);
      end
    end
  end

  task automatic drive_idle();
    bus.core_req_i   = 1'b0;
    bus.core_write_i = 1'b0;
    bus.core_addr_i  = '0;
    bus.core_wdata_i = '0;
    bus.core_wmask_i = '0;
    bus.core_rmask_i = '0;
    bus.host_req_i   = 1'b0;
    bus.host_write_i = 1'b0;
    bus.host_addr_i  = '0;
    bus.host_wdata_i = '0;
    bus.host_wmask_i = '0;
    busy             = 1'b0;
    {err_rv, drop_rv, inj_rv} = 3'b000;
  endtask

  // One request cycle; flags = {rerror, drop rvalid, inject rvalid} for its response
  task automatic step(input bit creq, input bit cwr, input logic [AW-1:0] caddr,
                      input bit hreq, input bit hwr, input logic [AW-1:0] haddr,
                      input bit bsy, input bit [2:0] flags,
                      input bit e_gnt, input bit e_dreq, input bit e_starve, input bit e_proto,
                      input int e_kind, input bit e_err, input logic [W-1:0] e_data);
    exp_t e;
    @(posedge clk);
    #2;
    bus.core_req_i   = creq;
    bus.core_write_i = cwr;
    bus.core_addr_i  = caddr;
    bus.core_wdata_i = PAT_11;
    bus.core_wmask_i = '1;
    bus.core_rmask_i = '1;
    bus.host_req_i   = hreq;
    bus.host_write_i = hwr;
    bus.host_addr_i  = haddr;
    bus.host_wdata_i = PAT_22;
    bus.host_wmask_i = '1;
    busy             = bsy;
    {err_rv, drop_rv, inj_rv} = flags;
    @(negedge clk);
    chk("host_gnt", bus.host_gnt_o, e_gnt);
    chk("dmem_req", bus.dmem_req_o, e_dreq);
    chk("host_starve", host_starve, e_starve);
    chk("proto_err", proto_err, e_proto);
    if (e_dreq) chk("dmem_addr", bus.dmem_addr_o, creq ? caddr : haddr);
    if (e_kind != 0) begin
      e.kind = e_kind;
      e.err  = e_err;
      e.data = e_data;
      e.due  = cycle_no + 1;
      q.push_back(e);
    end
  endtask

  task automatic idle(input bit e_proto);
    step(0, 0, '0, 0, 0, '0, 0, 3'b000, 0, 0, 0, e_proto, 0, 0, '0);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    drive_idle();
    q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_outputs",
          {bus.host_gnt_o, bus.dmem_req_o, bus.dmem_write_o, bus.dmem_addr_o,
           bus.core_rvalid_o, bus.core_rerror_o, bus.host_rvalid_o, bus.host_rerror_o,
           host_starve, proto_err, |bus.core_rdata_o, |bus.host_rdata_o,
           |bus.dmem_wdata_o, |bus.dmem_rmask_o}, '0);
    end
    @(posedge clk);
    #2;
    rst_ni = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("post_reset_rvalid", {bus.core_rvalid_o, bus.host_rvalid_o}, '0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    cycle_no = 0;
    rst_ni   = 1'b0;
    drive_idle();
    do_reset();

    // Core read, then core read carrying an integrity error
    step(1, 0, 12'h040, 0, 0, '0, 0, 3'b000, 0, 1, 0, 0, 1, 0, PAT_A5);
    idle(0);
    step(1, 0, 12'h080, 0, 0, '0, 0, 3'b100, 0, 1, 0, 0, 1, 1, PAT_3C);
    idle(0);

    // Core and host together for 3 cycles: host granted in the 4th only
    for (int i = 0; i < 3; i++)
      step(1, 0, 12'h080, 1, 0, 12'h100, 0, 3'b000, 0, 1, 0, 0, 1, 0, PAT_3C);
    step(0, 0, '0, 1, 0, 12'h100, 0, 3'b000, 1, 1, 0, 0, 2, 0, PAT_5A);
    idle(0);

    // Host write then back-to-back read-back
    step(0, 0, '0, 1, 1, 12'h200, 0, 3'b000, 1, 1, 0, 0, 2, 0, '0);
    step(0, 0, '0, 1, 0, 12'h200, 0, 3'b000, 1, 1, 0, 0, 2, 0, PAT_22);
    idle(0);

    // Blocked host write while busy
    step(0, 0, '0, 1, 1, 12'h300, 1, 3'b000, 1, 0, 0, 0, 2, 1, '0);
    idle(0);
    chk("blocked_write_mem", mem[12'h300], PAT_77);

    // Busy rises with a host read in flight
    step(0, 0, '0, 1, 0, 12'h040, 0, 3'b000, 1, 1, 0, 0, 2, 0, PAT_A5);
    step(0, 0, '0, 1, 1, 12'h300, 1, 3'b000, 1, 0, 0, 0, 2, 1, '0);
    idle(0);
    chk("blocked_write_mem2", mem[12'h300], PAT_77);

    // Starvation under continuous core writes
    for (int i = 0; i < 32; i++)
      step(1, 1, 12'h400, 1, 0, 12'h100, 0, 3'b000, 0, 1, (i == 15 || i == 31), 0, 0, 0, '0);
    step(0, 0, '0, 1, 0, 12'h100, 0, 3'b000, 1, 1, 0, 0, 2, 0, PAT_5A);
    idle(0);
    chk("core_write_mem", mem[12'h400], PAT_11);

    // Spurious rvalid after a core write
    step(1, 1, 12'h400, 0, 0, '0, 0, 3'b001, 0, 1, 0, 0, 0, 0, '0);
    idle(0);
    for (int i = 0; i < 3; i++) idle(1);
    do_reset();

    // Missing rvalid after a host read
    step(0, 0, '0, 1, 0, 12'h100, 0, 3'b010, 1, 1, 0, 0, 0, 0, '0);
    idle(0);
    for (int i = 0; i < 2; i++) idle(1);
    do_reset();

    // Reset while a host read response is outstanding
    step(0, 0, '0, 1, 0, 12'h100, 0, 3'b000, 1, 1, 0, 0, 0, 0, '0);
    @(posedge clk);
    #2;
    do_reset();
    idle(0);
    idle(0);

    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
